// File: rtl/pixel_shift_scheduler_if.sv
// Handshake, sprite-attribute and shift-control signals of the pixel shift scheduler.
// The underrun_cnt field exists only when UNDERRUN_CNT_EN is defined.
interface pixel_shift_scheduler_if #(
    parameter int unsigned X_W = 8
);
    logic                  line_start;
    logic                  pixel_tick;
    logic [7:0][X_W-1:0]   sprite_x;
    logic [7:0]            sprite_en;
    logic                  spr_valid;
    logic                  bg_valid;
    logic                  spr_req;
    logic                  bg_req;
    logic                  load_sprite;
    logic                  load_background;
    logic [8:0]            enable;
    logic [7:0]            spr_vis;
    logic                  active;
    logic                  line_done;
    logic                  underrun;
`ifdef UNDERRUN_CNT_EN
    logic [7:0]            underrun_cnt;
`endif

    modport master (
`ifdef UNDERRUN_CNT_EN
        output underrun_cnt,
`endif
        input  line_start, pixel_tick, sprite_x, sprite_en, spr_valid, bg_valid,
        output spr_req, bg_req, load_sprite, load_background, enable, spr_vis,
        output active, line_done, underrun
    );

    modport slave (
`ifdef UNDERRUN_CNT_EN
        input  underrun_cnt,
`endif
        output line_start, pixel_tick, sprite_x, sprite_en, spr_valid, bg_valid,
        input  spr_req, bg_req, load_sprite, load_background, enable, spr_vis,
        input  active, line_done, underrun
    );
endinterface

// File: rtl/pixel_shift_scheduler.sv
// Per-scanline fetch/prime/shift sequencer for 8 sprite and 1 background shift registers.
// Define UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module pixel_shift_scheduler #(
    parameter int unsigned LINE_PIXELS = 256,
    parameter int unsigned X_W         = 8
) (
    input logic                     clk,
    input logic                     reset,
    pixel_shift_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        StIdle, StSprFetch, StBgFetch, StPrime, StActive, StDone
    } state_e;

    localparam logic [X_W-1:0] LastPix = X_W'(LINE_PIXELS - 1);

    state_e         state_q, state_d;
    logic [X_W-1:0] hpos_q;
    logic [4:0]     bg_left_q;
    logic           bg_pend_q;
    logic [7:0]     spr_vis_q;
    logic           underrun_q;
    logic           tick;
    logic           bg_empty;
    logic [7:0]     spr_hit;

    assign tick     = (state_q == StActive) && bus.pixel_tick;
    assign bg_empty = (bg_left_q == 5'd0);

    // Window test is one bit wider than X_W so x+16 never wraps back into the line.
    for (genvar gi = 0; gi < 8; gi++) begin : g_win
        logic [X_W:0] x_lo, x_hi, p_ext;
        assign x_lo        = {1'b0, bus.sprite_x[gi]};
        assign x_hi        = x_lo + (X_W + 1)'(16);
        assign p_ext       = {1'b0, hpos_q};
        assign spr_hit[gi] = bus.sprite_en[gi] && (p_ext >= x_lo) && (p_ext < x_hi);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (bus.line_start) state_d = StSprFetch;
            StSprFetch: if (bus.spr_valid)  state_d = StBgFetch;
            StBgFetch:  if (bus.bg_valid)   state_d = StPrime;
            StPrime:    state_d = StActive;
            StActive:   if (tick && (hpos_q == LastPix)) state_d = StDone;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.spr_req         = 1'b0;
        bus.bg_req          = 1'b0;
        bus.load_sprite     = 1'b0;
        bus.load_background = 1'b0;
        bus.enable          = '0;
        case (state_q)
            StSprFetch: begin
                bus.spr_req     = 1'b1;
                bus.load_sprite = bus.spr_valid;
            end
            StBgFetch: begin
                bus.bg_req          = 1'b1;
                bus.load_background = bus.bg_valid;
            end
            StPrime: bus.enable[8] = 1'b1;
            StActive: begin
                bus.bg_req = bg_empty;
                // A word arriving on a tick cycle is loaded on the following (tick-free) cycle.
                bus.load_background = bg_empty && !bus.pixel_tick && (bus.bg_valid || bg_pend_q);
                if (bus.pixel_tick) bus.enable = {!bg_empty, spr_hit};
            end
            default: ;
        endcase
    end

    assign bus.active    = (state_q == StActive);
    assign bus.line_done = (state_q == StDone);
    assign bus.spr_vis   = spr_vis_q;
    assign bus.underrun  = underrun_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hpos_q     <= '0;
            bg_left_q  <= '0;
            bg_pend_q  <= 1'b0;
            spr_vis_q  <= '0;
            underrun_q <= 1'b0;
        end else begin
            if (state_q == StPrime) begin
                hpos_q    <= '0;
                bg_left_q <= 5'd15;
            end
            if (bus.load_background) bg_left_q <= 5'd16;
            if (tick) begin
                hpos_q    <= hpos_q + X_W'(1);
                spr_vis_q <= spr_hit;
                if (bg_empty) underrun_q <= 1'b1;
                else          bg_left_q  <= bg_left_q - 5'd1;
            end
            bg_pend_q <= (state_q == StActive) && bg_empty && !bus.load_background &&
                         (bg_pend_q || (bus.bg_valid && bus.pixel_tick));
        end
    end

`ifdef UNDERRUN_CNT_EN
    logic [7:0] underrun_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            underrun_cnt_q <= '0;
        end else if (tick && bg_empty && (underrun_cnt_q != 8'hFF)) begin
            underrun_cnt_q <= underrun_cnt_q + 8'd1;
        end
    end

    assign bus.underrun_cnt = underrun_cnt_q;
`endif
endmodule

// File: tb/tb_pixel_shift_scheduler.sv
// Randomised self-checking bench for pixel_shift_scheduler against a per-line behavioural model.
// Also checks underrun_cnt when UNDERRUN_CNT_EN is defined.
module tb_pixel_shift_scheduler;
    localparam int LINE = 256;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pixel_shift_scheduler_if #(.X_W(8)) bus ();

    pixel_shift_scheduler #(.LINE_PIXELS(LINE), .X_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0, n_bad = 0, n_print = 0;
    // Model: phase 0 idle,1 sprite fetch,2 bg fetch,3 prime,4 active,5 done.
    int m_phase = 0, m_p = 0, m_bg = 0, m_cnt = 0;
    bit m_defer = 0, m_under = 0;
    logic [7:0] m_vis = '0;
    bit chk_en = 0, coll_prev = 0, last_tick = 0;
    int n_done = 0, n_ld_act = 0, n_ticks = 0, n_en3 = 0, n_overlap = 0, n_p15_low = 0;
    int n_coll_ld = 0;
    int tick_mode = 0, bg_mode = 3, spr_prob = 100, bg_prob = 100;
    bit stray_ls = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_print < 40) begin
                n_print++;
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
            end
        end
    endtask

    function automatic logic [7:0] exp_hits();
        logic [7:0] h;
        h = '0;
        for (int i = 0; i < 8; i++) begin
            int x;
            x = int'(bus.sprite_x[i]);
            h[i] = bus.sprite_en[i] && (x <= m_p) && (m_p < x + 16);
        end
        return h;
    endfunction

    task automatic check_outputs();
        bit tk;
        logic [8:0] e_en;
        bit e_ld;
        tk   = (m_phase == 4) && bus.pixel_tick;
        e_en = '0;
        if (m_phase == 3) e_en = 9'h100;
        if (tk) e_en = {m_bg > 0, exp_hits()};
        e_ld = (m_phase == 2 && bus.bg_valid) ||
               (m_phase == 4 && m_bg == 0 && !bus.pixel_tick && (bus.bg_valid || m_defer));
        chk("spr_req", bus.spr_req, m_phase == 1);
        chk("load_sprite", bus.load_sprite, m_phase == 1 && bus.spr_valid);
        chk("bg_req", bus.bg_req, m_phase == 2 || (m_phase == 4 && m_bg == 0));
        chk("load_background", bus.load_background, e_ld);
        chk("enable", bus.enable, e_en);
        chk("spr_vis", bus.spr_vis, m_vis);
        chk("active", bus.active, m_phase == 4);
        chk("line_done", bus.line_done, m_phase == 5);
        chk("underrun", bus.underrun, m_under);
`ifdef UNDERRUN_CNT_EN
        chk("underrun_cnt", bus.underrun_cnt, m_cnt);
`endif
        if (coll_prev) begin
            chk("deferred_load", bus.load_background, 1);
            if (bus.load_background) n_coll_ld++;
        end
        coll_prev = tk && bus.bg_valid && m_bg == 0 && m_p != LINE - 1;
    endtask

    task automatic model_update();
        bit tk, ld, nd;
        if (!reset) begin
            m_phase = 0; m_p = 0; m_bg = 0; m_defer = 0; m_vis = '0; m_under = 0; m_cnt = 0;
            return;
        end
        case (m_phase)
            0: if (bus.line_start) m_phase = 1;
            1: if (bus.spr_valid) m_phase = 2;
            2: if (bus.bg_valid) begin m_bg = 16; m_phase = 3; end
            3: begin m_bg = 15; m_p = 0; m_phase = 4; end
            4: begin
                tk = bus.pixel_tick;
                ld = (m_bg == 0) && !tk && (bus.bg_valid || m_defer);
                nd = (m_bg == 0) && !ld && (m_defer || (bus.bg_valid && tk));
                if (tk) begin
                    m_vis = exp_hits();
                    if (m_bg > 0) m_bg--;
                    else begin
                        m_under = 1;
                        if (m_cnt < 255) m_cnt++;
                    end
                    if (m_p == LINE - 1) m_phase = 5;
                    m_p++;
                end
                if (ld) m_bg = 16;
                m_defer = nd;
            end
            default: m_phase = 0;
        endcase
        if (m_phase != 4) m_defer = 0;
    endtask

    task automatic step();
        @(negedge clk);
        if (chk_en) begin
            check_outputs();
            if (bus.line_done) n_done++;
            if (bus.active && bus.load_background) n_ld_act++;
            if (bus.active && bus.pixel_tick) n_ticks++;
            if (bus.active && bus.pixel_tick && bus.enable[3]) n_en3++;
            if (bus.load_background && bus.enable[8]) n_overlap++;
            if (bus.active && bus.pixel_tick && m_p == 15 && !bus.enable[8]) n_p15_low++;
        end
        @(posedge clk);
        model_update();
        last_tick = bus.pixel_tick;
        #1;
    endtask

    task automatic drive_inputs();
        bit t;
        t = (tick_mode == 0) ? !last_tick : (!last_tick && ($urandom_range(0, 1) == 1));
        bus.pixel_tick = t;
        bus.spr_valid  = ($urandom_range(0, 99) < spr_prob);
        case (bg_mode)
            0: bus.bg_valid = ($urandom_range(0, 99) < bg_prob);
            1: bus.bg_valid = (m_phase == 2);
            2: bus.bg_valid = (m_phase == 2) || (m_phase == 4 && t && m_p == 15);
            default: bus.bg_valid = 1'b1;
        endcase
        bus.line_start = stray_ls && ($urandom_range(0, 49) == 0);
    endtask

    task automatic run_line(input int reset_at);
        bit fin;
        fin = 0;
        drive_inputs();
        bus.line_start = 1'b1;
        step();
        for (int i = 0; i < 3000 && !fin; i++) begin
            drive_inputs();
            if (reset_at >= 0 && m_phase == 4 && m_p == reset_at) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
                return;
            end
            step();
            if (m_phase == 0) fin = 1;
        end
        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL line_timeout: line still running in phase %0d, required end", m_phase);
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        for (int i = 0; i < cycles; i++) begin drive_inputs(); bus.line_start = 0; step(); end
        reset = 1'b1;
    endtask

    task automatic rand_sprites();
        for (int i = 0; i < 8; i++) bus.sprite_x[i] = 8'($urandom_range(0, 255));
        bus.sprite_en = 8'($urandom_range(0, 255));
    endtask

    int s_done, s_ld, s_ticks, s_en3;

    initial begin
        reset = 1'b0;
        bus.line_start = 0; bus.pixel_tick = 0; bus.spr_valid = 0; bus.bg_valid = 0;
        rand_sprites();
        step();
        chk_en = 1;
        do_reset(2);
        chk("rst_active", bus.active, 0);
        chk("rst_enable", bus.enable, 0);
        chk("rst_spr_vis", bus.spr_vis, 0);
        chk("rst_underrun", bus.underrun, 0);

        // Nominal line: tick every other clock, background always available.
        s_done = n_done; s_ld = n_ld_act; s_ticks = n_ticks;
        run_line(-1);
        chk("nom_ticks", n_ticks - s_ticks, 256);
        chk("nom_active_bg_loads", n_ld_act - s_ld, 16);
        chk("nom_line_done", n_done - s_done, 1);
        chk("nom_underrun", bus.underrun, 0);

        // Sprite 3 at x=250 is clipped to six pixels.
        bus.sprite_en = 8'h08;
        bus.sprite_x[3] = 8'd250;
        s_en3 = n_en3;
        run_line(-1);
        chk("win_en3_ticks", n_en3 - s_en3, 6);
        chk("win_vis3_held", bus.spr_vis[3], 1);

        // Starvation after the first background word.
        rand_sprites();
        bg_mode = 1;
        run_line(-1);
        chk("starve_underrun", bus.underrun, 1);
        chk("starve_p15_bg_off", n_p15_low, 1);
`ifdef UNDERRUN_CNT_EN
        chk("starve_cnt", bus.underrun_cnt, 241);
`endif
        do_reset(1);
        chk("starve_cleared", bus.underrun, 0);

        // bg_valid only on the tick of pixel 15: load must slip one cycle.
        bg_mode = 2;
        run_line(-1);
        chk("coll_deferred_loads", n_coll_ld, 1);
        chk("coll_overlap", n_overlap, 0);
        do_reset(1);

        // Reset when hpos reaches 100, then a clean line.
        bg_mode = 3;
        s_done = n_done;
        run_line(100);
        chk("midrst_active", bus.active, 0);
        chk("midrst_enable", bus.enable, 0);
        chk("midrst_bg_req", bus.bg_req, 0);
        chk("midrst_no_done", n_done - s_done, 0);
        s_done = n_done; s_ticks = n_ticks;
        run_line(-1);
        chk("after_rst_done", n_done - s_done, 1);
        chk("after_rst_ticks", n_ticks - s_ticks, 256);

        // Stray line_start pulses while busy.
        stray_ls = 1;
        s_done = n_done;
        run_line(-1);
        chk("stray_ls_done", n_done - s_done, 1);

        // Random lines: irregular ticks, sporadic fetch grants.
        tick_mode = 1;
        bg_mode = 0;
        spr_prob = 30;
        for (int l = 0; l < 4; l++) begin
            rand_sprites();
            bg_prob = $urandom_range(20, 100);
            run_line(-1);
        end
        chk("rand_overlap", n_overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
